// File: rtl/gol_sim_sequencer.sv
// Game of Life phase sequencer: frame-aligned init/clear/update/copy
// engine control with pause, single-step and engine timeout.
module gol_sim_sequencer #(
    parameter int INTERVAL = 2400000,
    parameter int TIMER_W  = 22,
    parameter int TIMEOUT  = 4096,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             randomize,
    input  logic             clear,
    input  logic             frame_tick,
    output logic             init_start,
    output logic             clear_start,
    output logic             update_start,
    output logic             copy_start,
    input  logic             init_done,
    input  logic             clear_done,
    input  logic             update_done,
    input  logic             copy_done,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [GEN_W-1:0] generation,
    output logic             timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_INIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_COPY   = 3'd4,
        S_CLEAR  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    state_e             kind_q, kind_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               step_pend_q, step_pend_d;
    logic               clear_pend_q, clear_pend_d;
    logic               err_q, err_d;

    logic trig;
    logic done_sel;
    logic step_clr;
    logic clr_clr;
    logic start_cyc;

    // cnt_q is zero exactly in the first cycle of an engine phase
    assign start_cyc = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        gen_d    = gen_q;
        err_d    = err_q;
        trig     = 1'b0;
        done_sel = 1'b0;
        step_clr = 1'b0;
        clr_clr  = 1'b0;

        unique case (state_q)
            S_INIT:   done_sel = init_done;
            S_CLEAR:  done_sel = clear_done;
            S_UPDATE: done_sel = update_done;
            S_COPY:   done_sel = copy_done;
            default:  done_sel = 1'b0;
        endcase

        unique case (state_q)
            S_IDLE: begin
                trig = clear_pend_q | step_pend_q
                     | (run & (timer_q == T_LAST));
                if (trig) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                    if (clear_pend_q) begin
                        kind_d = S_CLEAR;
                    end else begin
                        kind_d   = randomize ? S_INIT : S_UPDATE;
                        step_clr = 1'b1;
                    end
                end else if (run && timer_q != T_LAST) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d = kind_q;
                    cnt_d   = '0;
                    clr_clr = (kind_q == S_CLEAR);
                end
            end
            S_INIT, S_UPDATE, S_COPY, S_CLEAR: begin
                cnt_d = cnt_q + TO_W'(1);
                if (!start_cyc && done_sel) begin
                    cnt_d = '0;
                    unique case (state_q)
                        S_UPDATE: state_d = S_COPY;
                        S_COPY: begin
                            state_d = S_IDLE;
                            gen_d   = gen_q + GEN_W'(1);
                        end
                        S_INIT: begin
                            state_d = S_IDLE;
                            gen_d   = '0;
                            err_d   = 1'b0;
                        end
                        default: begin
                            state_d = S_IDLE;
                            gen_d   = '0;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a fresh request in the same cycle outranks consuming the old one
        step_pend_d  = (step_pend_q & ~step_clr) | step;
        clear_pend_d = (clear_pend_q & ~clr_clr) | clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            kind_q       <= S_UPDATE;
            timer_q      <= '0;
            cnt_q        <= '0;
            gen_q        <= '0;
            step_pend_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            gen_q        <= gen_d;
            step_pend_q  <= step_pend_d;
            clear_pend_q <= clear_pend_d;
            err_q        <= err_d;
        end
    end

    assign init_start   = ~reset & start_cyc & (state_q == S_INIT);
    assign clear_start  = ~reset & start_cyc & (state_q == S_CLEAR);
    assign update_start = ~reset & start_cyc & (state_q == S_UPDATE);
    assign copy_start   = ~reset & start_cyc & (state_q == S_COPY);
    assign busy         = (state_q != S_IDLE);
    assign phase        = state_q;
    assign generation   = gen_q;
    assign timeout_err  = err_q;

endmodule
